// File: rtl/udma_periph_cfg_resp.sv
`default_nettype none
// udma_periph_cfg_resp: uDMA config-bus responder (RX/TX channel regs, setup reg, programmable wait states).
// Optional UDMA_CFG_ADDR_ERR_EN adds cfg_err_o flagging unmapped accesses.  Rev 1.0
module udma_periph_cfg_resp #(
  parameter int L2_AWIDTH_NOAL = 19,
  parameter int TRANS_SIZE     = 20,
  parameter int WAIT_CYCLES    = 0
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [31:0]               cfg_data_i,
  input  logic [4:0]                cfg_addr_i,
  input  logic                      cfg_valid_i,
  input  logic                      cfg_rwn_i,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_ready_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_rx_size_o,
  output logic                      cfg_rx_continuous_o,
  output logic [1:0]                cfg_rx_datasize_o,
  output logic                      cfg_rx_en_o,
  output logic                      cfg_rx_clr_o,
  input  logic                      cfg_rx_en_i,
  input  logic                      cfg_rx_pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_tx_size_o,
  output logic                      cfg_tx_continuous_o,
  output logic [1:0]                cfg_tx_datasize_o,
  output logic                      cfg_tx_en_o,
  output logic                      cfg_tx_clr_o,
  input  logic                      cfg_tx_en_i,
  input  logic                      cfg_tx_pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_tx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_tx_bytes_left_i,
  output logic [31:0]               cfg_setup_o
`ifdef UDMA_CFG_ADDR_ERR_EN
  ,
  output logic                      cfg_err_o
`endif
);

  localparam logic [4:0] REG_RX_SADDR = 5'd0;
  localparam logic [4:0] REG_RX_SIZE  = 5'd1;
  localparam logic [4:0] REG_RX_CFG   = 5'd2;
  localparam logic [4:0] REG_TX_SADDR = 5'd4;
  localparam logic [4:0] REG_TX_SIZE  = 5'd5;
  localparam logic [4:0] REG_TX_CFG   = 5'd6;
  localparam logic [4:0] REG_SETUP    = 5'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef UDMA_CFG_ADDR_ERR_EN
  localparam logic [31:0] UNMAPPED_RDATA = 32'hBADACCE5;
`else
  localparam logic [31:0] UNMAPPED_RDATA = 32'h0;
`endif

  logic [1:0]                state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      ready_q, ready_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [L2_AWIDTH_NOAL-1:0] rx_startaddr_q, rx_startaddr_d, tx_startaddr_q, tx_startaddr_d;
  logic [TRANS_SIZE-1:0]     rx_size_q, rx_size_d, tx_size_q, tx_size_d;
  logic                      rx_continuous_q, rx_continuous_d, tx_continuous_q, tx_continuous_d;
  logic [1:0]                rx_datasize_q, rx_datasize_d, tx_datasize_q, tx_datasize_d;
  logic                      rx_en_q, rx_en_d, rx_clr_q, rx_clr_d;
  logic                      tx_en_q, tx_en_d, tx_clr_q, tx_clr_d;
  logic [31:0]               setup_q, setup_d;
  logic [31:0]               rd_val;
  logic                      enter_ack;
  logic                      wr_commit;

  always_comb begin
    rd_val = UNMAPPED_RDATA;
    case (cfg_addr_i)
      REG_RX_SADDR: rd_val = 32'(cfg_rx_curr_addr_i);
      REG_RX_SIZE:  rd_val = 32'(cfg_rx_bytes_left_i);
      REG_RX_CFG:   rd_val = {25'd0, 1'b0, cfg_rx_pending_i, cfg_rx_en_i, 1'b0,
                              rx_datasize_q, rx_continuous_q};
      REG_TX_SADDR: rd_val = 32'(cfg_tx_curr_addr_i);
      REG_TX_SIZE:  rd_val = 32'(cfg_tx_bytes_left_i);
      REG_TX_CFG:   rd_val = {25'd0, 1'b0, cfg_tx_pending_i, cfg_tx_en_i, 1'b0,
                              tx_datasize_q, tx_continuous_q};
      REG_SETUP:    rd_val = setup_q;
      default:      rd_val = UNMAPPED_RDATA;
    endcase
  end

  // A valid that drops while waiting abandons the access without touching any register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enter_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid_i) begin
          if (WAIT_CYCLES == 0) begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!cfg_valid_i) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d   = ST_ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_commit = (state_q == ST_ACK) && cfg_valid_i && !cfg_rwn_i;

  always_comb begin
    ready_d         = enter_ack;
    rdata_d         = enter_ack ? (cfg_rwn_i ? rd_val : 32'd0) : rdata_q;
    rx_startaddr_d  = rx_startaddr_q;
    rx_size_d       = rx_size_q;
    rx_continuous_d = rx_continuous_q;
    rx_datasize_d   = rx_datasize_q;
    tx_startaddr_d  = tx_startaddr_q;
    tx_size_d       = tx_size_q;
    tx_continuous_d = tx_continuous_q;
    tx_datasize_d   = tx_datasize_q;
    setup_d         = setup_q;
    rx_en_d         = 1'b0;
    rx_clr_d        = 1'b0;
    tx_en_d         = 1'b0;
    tx_clr_d        = 1'b0;
    if (wr_commit) begin
      case (cfg_addr_i)
        REG_RX_SADDR: rx_startaddr_d = cfg_data_i[L2_AWIDTH_NOAL-1:0];
        REG_RX_SIZE:  rx_size_d      = cfg_data_i[TRANS_SIZE-1:0];
        REG_RX_CFG: begin
          rx_continuous_d = cfg_data_i[0];
          rx_datasize_d   = cfg_data_i[2:1];
          rx_clr_d        = cfg_data_i[6];
          rx_en_d         = cfg_data_i[4] & ~cfg_data_i[6];
        end
        REG_TX_SADDR: tx_startaddr_d = cfg_data_i[L2_AWIDTH_NOAL-1:0];
        REG_TX_SIZE:  tx_size_d      = cfg_data_i[TRANS_SIZE-1:0];
        REG_TX_CFG: begin
          tx_continuous_d = cfg_data_i[0];
          tx_datasize_d   = cfg_data_i[2:1];
          tx_clr_d        = cfg_data_i[6];
          tx_en_d         = cfg_data_i[4] & ~cfg_data_i[6];
        end
        REG_SETUP:    setup_d = cfg_data_i;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 4'd0;
      ready_q         <= 1'b0;
      rdata_q         <= 32'd0;
      rx_startaddr_q  <= '0;
      rx_size_q       <= '0;
      rx_continuous_q <= 1'b0;
      rx_datasize_q   <= 2'd0;
      tx_startaddr_q  <= '0;
      tx_size_q       <= '0;
      tx_continuous_q <= 1'b0;
      tx_datasize_q   <= 2'd0;
      setup_q         <= 32'd0;
      rx_en_q         <= 1'b0;
      rx_clr_q        <= 1'b0;
      tx_en_q         <= 1'b0;
      tx_clr_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ready_q         <= ready_d;
      rdata_q         <= rdata_d;
      rx_startaddr_q  <= rx_startaddr_d;
      rx_size_q       <= rx_size_d;
      rx_continuous_q <= rx_continuous_d;
      rx_datasize_q   <= rx_datasize_d;
      tx_startaddr_q  <= tx_startaddr_d;
      tx_size_q       <= tx_size_d;
      tx_continuous_q <= tx_continuous_d;
      tx_datasize_q   <= tx_datasize_d;
      setup_q         <= setup_d;
      rx_en_q         <= rx_en_d;
      rx_clr_q        <= rx_clr_d;
      tx_en_q         <= tx_en_d;
      tx_clr_q        <= tx_clr_d;
    end
  end

`ifdef UDMA_CFG_ADDR_ERR_EN
  logic addr_mapped;
  logic err_q, err_d;

  assign addr_mapped = cfg_addr_i inside {REG_RX_SADDR, REG_RX_SIZE, REG_RX_CFG,
                                          REG_TX_SADDR, REG_TX_SIZE, REG_TX_CFG, REG_SETUP};
  assign err_d       = enter_ack & ~addr_mapped;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign cfg_err_o = err_q;
`endif

  assign cfg_ready_o         = ready_q;
  assign cfg_data_o          = rdata_q;
  assign cfg_rx_startaddr_o  = rx_startaddr_q;
  assign cfg_rx_size_o       = rx_size_q;
  assign cfg_rx_continuous_o = rx_continuous_q;
  assign cfg_rx_datasize_o   = rx_datasize_q;
  assign cfg_rx_en_o         = rx_en_q;
  assign cfg_rx_clr_o        = rx_clr_q;
  assign cfg_tx_startaddr_o  = tx_startaddr_q;
  assign cfg_tx_size_o       = tx_size_q;
  assign cfg_tx_continuous_o = tx_continuous_q;
  assign cfg_tx_datasize_o   = tx_datasize_q;
  assign cfg_tx_en_o         = tx_en_q;
  assign cfg_tx_clr_o        = tx_clr_q;
  assign cfg_setup_o         = setup_q;

endmodule
`default_nettype wire

// File: tb/tb_udma_periph_cfg_resp.sv
`default_nettype none
// tb_udma_periph_cfg_resp: two responders (0 and 3 wait states) checked against a register-map model.
module tb_udma_periph_cfg_resp;

`ifdef UDMA_CFG_ADDR_ERR_EN
  localparam logic [31:0] NO_MAP_DATA = 32'hBADACCE5;
`else
  localparam logic [31:0] NO_MAP_DATA = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] wdata = '0;
  logic [4:0]  addr = '0;
  logic        rwn = 1'b0;
  logic        valid0 = 1'b0, valid3 = 1'b0;
  logic        rx_en_i = 1'b0, tx_en_i = 1'b0, rx_pend = 1'b0, tx_pend = 1'b0;
  logic [18:0] rx_curr = '0, tx_curr = '0;
  logic [19:0] rx_bl = '0, tx_bl = '0;

  logic [31:0] rdata_0, rdata_3, setup_0, setup_3;
  logic        ready_0, ready_3;
  logic [18:0] rx_sa_0, rx_sa_3, tx_sa_0, tx_sa_3;
  logic [19:0] rx_sz_0, rx_sz_3, tx_sz_0, tx_sz_3;
  logic        rx_ct_0, rx_ct_3, tx_ct_0, tx_ct_3;
  logic [1:0]  rx_ds_0, rx_ds_3, tx_ds_0, tx_ds_3;
  logic        rx_en_0, rx_en_3, rx_clr_0, rx_clr_3;
  logic        tx_en_0, tx_en_3, tx_clr_0, tx_clr_3;
`ifdef UDMA_CFG_ADDR_ERR_EN
  logic        err_0, err_3;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: register contents and pending one-cycle pulses, per DUT (0: no wait, 1: 3 waits).
  logic [31:0] m_rx_sa[2], m_tx_sa[2], m_rx_sz[2], m_tx_sz[2];
  logic [31:0] m_rx_ct[2], m_tx_ct[2], m_rx_ds[2], m_tx_ds[2], m_setup[2];
  logic [31:0] m_rx_en[2], m_rx_clr[2], m_tx_en[2], m_tx_clr[2];

  always #5 clk = ~clk;

  udma_periph_cfg_resp #(.L2_AWIDTH_NOAL(19), .TRANS_SIZE(20), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rstn_i(rstn), .cfg_data_i(wdata), .cfg_addr_i(addr),
    .cfg_valid_i(valid0), .cfg_rwn_i(rwn), .cfg_data_o(rdata_0), .cfg_ready_o(ready_0),
    .cfg_rx_startaddr_o(rx_sa_0), .cfg_rx_size_o(rx_sz_0), .cfg_rx_continuous_o(rx_ct_0),
    .cfg_rx_datasize_o(rx_ds_0), .cfg_rx_en_o(rx_en_0), .cfg_rx_clr_o(rx_clr_0),
    .cfg_rx_en_i(rx_en_i), .cfg_rx_pending_i(rx_pend), .cfg_rx_curr_addr_i(rx_curr),
    .cfg_rx_bytes_left_i(rx_bl),
    .cfg_tx_startaddr_o(tx_sa_0), .cfg_tx_size_o(tx_sz_0), .cfg_tx_continuous_o(tx_ct_0),
    .cfg_tx_datasize_o(tx_ds_0), .cfg_tx_en_o(tx_en_0), .cfg_tx_clr_o(tx_clr_0),
    .cfg_tx_en_i(tx_en_i), .cfg_tx_pending_i(tx_pend), .cfg_tx_curr_addr_i(tx_curr),
    .cfg_tx_bytes_left_i(tx_bl),
    .cfg_setup_o(setup_0)
`ifdef UDMA_CFG_ADDR_ERR_EN
    , .cfg_err_o(err_0)
`endif
  );

  udma_periph_cfg_resp #(.L2_AWIDTH_NOAL(19), .TRANS_SIZE(20), .WAIT_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rstn_i(rstn), .cfg_data_i(wdata), .cfg_addr_i(addr),
    .cfg_valid_i(valid3), .cfg_rwn_i(rwn), .cfg_data_o(rdata_3), .cfg_ready_o(ready_3),
    .cfg_rx_startaddr_o(rx_sa_3), .cfg_rx_size_o(rx_sz_3), .cfg_rx_continuous_o(rx_ct_3),
    .cfg_rx_datasize_o(rx_ds_3), .cfg_rx_en_o(rx_en_3), .cfg_rx_clr_o(rx_clr_3),
    .cfg_rx_en_i(rx_en_i), .cfg_rx_pending_i(rx_pend), .cfg_rx_curr_addr_i(rx_curr),
    .cfg_rx_bytes_left_i(rx_bl),
    .cfg_tx_startaddr_o(tx_sa_3), .cfg_tx_size_o(tx_sz_3), .cfg_tx_continuous_o(tx_ct_3),
    .cfg_tx_datasize_o(tx_ds_3), .cfg_tx_en_o(tx_en_3), .cfg_tx_clr_o(tx_clr_3),
    .cfg_tx_en_i(tx_en_i), .cfg_tx_pending_i(tx_pend), .cfg_tx_curr_addr_i(tx_curr),
    .cfg_tx_bytes_left_i(tx_bl),
    .cfg_setup_o(setup_3)
`ifdef UDMA_CFG_ADDR_ERR_EN
    , .cfg_err_o(err_3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic string oname(input int w);
    case (w)
      0: return "rx_startaddr";  1: return "tx_startaddr";
      2: return "rx_size";       3: return "tx_size";
      4: return "rx_continuous"; 5: return "tx_continuous";
      6: return "rx_datasize";   7: return "tx_datasize";
      8: return "setup";         9: return "data_o";
      10: return "ready";        11: return "rx_en_pulse";
      12: return "rx_clr_pulse"; 13: return "tx_en_pulse";
      14: return "tx_clr_pulse"; default: return "err";
    endcase
  endfunction

  function automatic logic [31:0] outv(input int d, input int w);
    logic [31:0] v;
    v = 32'd0;
    case (w)
      0:  v = (d == 0) ? 32'(rx_sa_0)  : 32'(rx_sa_3);
      1:  v = (d == 0) ? 32'(tx_sa_0)  : 32'(tx_sa_3);
      2:  v = (d == 0) ? 32'(rx_sz_0)  : 32'(rx_sz_3);
      3:  v = (d == 0) ? 32'(tx_sz_0)  : 32'(tx_sz_3);
      4:  v = (d == 0) ? 32'(rx_ct_0)  : 32'(rx_ct_3);
      5:  v = (d == 0) ? 32'(tx_ct_0)  : 32'(tx_ct_3);
      6:  v = (d == 0) ? 32'(rx_ds_0)  : 32'(rx_ds_3);
      7:  v = (d == 0) ? 32'(tx_ds_0)  : 32'(tx_ds_3);
      8:  v = (d == 0) ? setup_0       : setup_3;
      9:  v = (d == 0) ? rdata_0       : rdata_3;
      10: v = (d == 0) ? 32'(ready_0)  : 32'(ready_3);
      11: v = (d == 0) ? 32'(rx_en_0)  : 32'(rx_en_3);
      12: v = (d == 0) ? 32'(rx_clr_0) : 32'(rx_clr_3);
      13: v = (d == 0) ? 32'(tx_en_0)  : 32'(tx_en_3);
      14: v = (d == 0) ? 32'(tx_clr_0) : 32'(tx_clr_3);
`ifdef UDMA_CFG_ADDR_ERR_EN
      15: v = (d == 0) ? 32'(err_0)    : 32'(err_3);
`endif
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] modv(input int d, input int w);
    case (w)
      0: return m_rx_sa[d];  1: return m_tx_sa[d];
      2: return m_rx_sz[d];  3: return m_tx_sz[d];
      4: return m_rx_ct[d];  5: return m_tx_ct[d];
      6: return m_rx_ds[d];  7: return m_tx_ds[d];
      8: return m_setup[d];
      11: return m_rx_en[d]; 12: return m_rx_clr[d];
      13: return m_tx_en[d]; 14: return m_tx_clr[d];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input int d, input logic [4:0] idx);
    case (idx)
      5'd0: return 32'(rx_curr);
      5'd1: return 32'(rx_bl);
      5'd2: return m_rx_ct[d] + (m_rx_ds[d] << 1) + (32'(rx_en_i) << 4) + (32'(rx_pend) << 5);
      5'd4: return 32'(tx_curr);
      5'd5: return 32'(tx_bl);
      5'd6: return m_tx_ct[d] + (m_tx_ds[d] << 1) + (32'(tx_en_i) << 4) + (32'(tx_pend) << 5);
      5'd8: return m_setup[d];
      default: return NO_MAP_DATA;
    endcase
  endfunction

  task automatic model_write(input int d, input logic [4:0] idx, input logic [31:0] wd);
    case (idx)
      5'd0: m_rx_sa[d] = wd & 32'h7FFFF;
      5'd1: m_rx_sz[d] = wd & 32'hFFFFF;
      5'd2: begin
        m_rx_ct[d] = wd & 32'h1;
        m_rx_ds[d] = (wd >> 1) & 32'h3;
        if (wd[6]) m_rx_clr[d] = 32'd1;
        else if (wd[4]) m_rx_en[d] = 32'd1;
      end
      5'd4: m_tx_sa[d] = wd & 32'h7FFFF;
      5'd5: m_tx_sz[d] = wd & 32'hFFFFF;
      5'd6: begin
        m_tx_ct[d] = wd & 32'h1;
        m_tx_ds[d] = (wd >> 1) & 32'h3;
        if (wd[6]) m_tx_clr[d] = 32'd1;
        else if (wd[4]) m_tx_en[d] = 32'd1;
      end
      5'd8: m_setup[d] = wd;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rx_sa[d] = 0; m_tx_sa[d] = 0; m_rx_sz[d] = 0; m_tx_sz[d] = 0;
      m_rx_ct[d] = 0; m_tx_ct[d] = 0; m_rx_ds[d] = 0; m_tx_ds[d] = 0; m_setup[d] = 0;
      m_rx_en[d] = 0; m_rx_clr[d] = 0; m_tx_en[d] = 0; m_tx_clr[d] = 0;
    end
  endtask

  task automatic check_range(input int d, input int lo, input int hi, input string when);
    for (int w = lo; w <= hi; w++)
      chk($sformatf("%s_d%0d_%s", when, d, oname(w)), outv(d, w), modv(d, w));
  endtask

  task automatic randomize_status();
    rx_en_i = 1'($urandom);  tx_en_i = 1'($urandom);
    rx_pend = 1'($urandom);  tx_pend = 1'($urandom);
    rx_curr = 19'($urandom); tx_curr = 19'($urandom);
    rx_bl   = 20'($urandom); tx_bl   = 20'($urandom);
  endtask

  task automatic access(input int d, input logic [4:0] idx, input logic r, input logic [31:0] wd);
    logic [31:0] exp_rd;
    int          lat, cyc;
    logic        seen;
    lat    = (d == 0) ? 1 : 4;
    exp_rd = r ? exp_read(d, idx) : 32'd0;
    @(negedge clk);
    addr = idx; rwn = r; wdata = wd;
    if (d == 0) valid0 = 1'b1; else valid3 = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      seen = (outv(d, 10) != 32'd0);
    end
    chk($sformatf("latency_d%0d_idx%0d", d, idx), 32'(cyc), 32'(lat));
    chk($sformatf("rdata_d%0d_idx%0d_rwn%0d", d, idx, r), outv(d, 9), exp_rd);
`ifdef UDMA_CFG_ADDR_ERR_EN
    chk($sformatf("err_d%0d_idx%0d", d, idx), outv(d, 15),
        (idx inside {5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd8}) ? 32'd0 : 32'd1);
`endif
    check_range(d, 0, 8, "precommit");
    if (!r) model_write(d, idx, wd);
    @(negedge clk);
    valid0 = 1'b0; valid3 = 1'b0;
    chk($sformatf("ready_one_cycle_d%0d", d), outv(d, 10), 32'd0);
    for (int k = 0; k < 2; k++) begin
      check_range(k, 0, 8, "commit");
      check_range(k, 11, 14, "pulse");
    end
    model_reset_pulses();
    @(negedge clk);
    check_range(d, 11, 14, "pulse_end");
  endtask

  task automatic model_reset_pulses();
    for (int d = 0; d < 2; d++) begin
      m_rx_en[d] = 0; m_rx_clr[d] = 0; m_tx_en[d] = 0; m_tx_clr[d] = 0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_range(0, 0, 15, "reset");
    check_range(1, 0, 15, "reset");
    rstn = 1'b1;

    // Directed steps
    access(0, 5'd0, 1'b0, 32'h1C000100);
    rx_bl = 20'h40;
    access(1, 5'd1, 1'b1, 32'h0);
    access(0, 5'd2, 1'b0, 32'h15);
    access(0, 5'd6, 1'b0, 32'h50);
    tx_pend = 1'b1; tx_en_i = 1'b1;
    access(0, 5'd6, 1'b1, 32'h0);
    access(1, 5'd2, 1'b0, 32'h5B);
    access(0, 5'd3, 1'b1, 32'h0);
    access(1, 5'd3, 1'b1, 32'h0);
    access(1, 5'd12, 1'b0, 32'hFFFFFFFF);
    access(0, 5'd8, 1'b0, 32'hA5A55A5A);

    // Randomized accesses on either responder
    for (int i = 0; i < 60; i++) begin
      randomize_status();
      access($urandom_range(0, 1), 5'($urandom_range(0, 15)), 1'($urandom), $urandom);
    end

    // Valid withdrawn while waiting: no ready, no register change
    @(negedge clk);
    addr = 5'd8; rwn = 1'b0; wdata = 32'hDEADBEEF; valid3 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("abort_wait_ready", 32'(ready_3), 32'd0);
    end
    valid3 = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_ready", 32'(ready_3), 32'd0);
    end
    check_range(1, 0, 8, "abort");
    check_range(1, 11, 14, "abort");
    access(1, 5'd8, 1'b1, 32'h0);

    // Reset while both responders are mid-access
    @(negedge clk);
    addr = 5'd2; rwn = 1'b0; wdata = 32'h17; valid0 = 1'b1; valid3 = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    model_reset();
    #1;
    check_range(0, 0, 15, "midreset");
    check_range(1, 0, 15, "midreset");
    @(negedge clk);
    valid0 = 1'b0; valid3 = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_range(0, 0, 15, "postreset");
      check_range(1, 0, 15, "postreset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
